serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor: computes diff = a - b, LSB first, one bit per clock.
- Uses a single 1-bit full-subtractor cell and a borrow flip-flop.
- Start/busy/done handshake.
- Companion to the team's combinational adder cells; the area-lean arithmetic path for the datapath lab modules.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when not busy
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when result valid
- diff  output  WIDTH  result a - b mod 2^WIDTH; held until next accepted start
- bout  output  1  final borrow (1 when a < b unsigned); held with diff
- ovf  output  1  signed overflow flag (see Optional Feature)

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; busy, done, bout, ovf = 0; diff = 0.
  - Internal shift registers, borrow FF and bit counter = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a rising edge loads a, b into shift regs; borrow FF = 0; counter = 0; go to RUN.
  - Otherwise stay in IDLE.
- RUN (busy=1), each cycle:
  - Cell inputs: x = a_sh[0], y = b_sh[0], bin = borrow FF.
  - d = x ^ y ^ bin.
  - bnext = (~x & y) | (~(x ^ y) & bin).
  - d shifts into diff_sh MSB; a_sh and b_sh shift right; borrow FF = bnext; counter++.
  - After the edge that processes bit WIDTH-1: go to DONE; diff = diff_sh with final d; bout = bnext.
- DONE (done=1, busy=0) for exactly one cycle, then IDLE.
  - start=1 during DONE is accepted: loads operands and goes directly to RUN. No idle bubble required.
- Latency: start accepted at edge k -> done high during the cycle after edge k+WIDTH. Throughput is one operation per WIDTH+1 cycles.
- start while busy=1 is ignored; operands are not re-sampled.
- a/b may change freely after the accepting edge.
- diff, bout, ovf update only on the RUN -> DONE edge; stable otherwise (including through IDLE).
- Reset mid-RUN aborts the operation: no done pulse; outputs return to reset values.
- Counter width: clog2(WIDTH). Terminal compare is counter == WIDTH-1. No wrap beyond it.

Optional Feature:
- Macro: SERIAL_SUB_SIGNED_OVF_EN.
- Defined:
  - Sign bits of a and b (MSBs at load) are captured into a 2-bit register.
  - On the RUN -> DONE edge: ovf = (a_msb != b_msb) && (final d != a_msb).
- Undefined:
  - ovf is tied 0; sign-capture register is not built.
  - The port remains present so the interface is identical.

Decomposition:
- Shared package (serial_arith_pkg):
  - State encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - Default WIDTH constant.
  - Counter-width function (clog2).
- Sub-module full_subtractor:
  - Combinational 1-bit cell; inputs x, y, bin; outputs d, bout_cell.
  - Instantiated once; the FSM, shift registers and borrow FF live in serial_subtractor.

Test Plan (WIDTH=8, macro defined unless noted):
- a=0x5A, b=0x23, start 1 cycle -> busy 8 cycles; done pulse 9 cycles after start edge; diff=0x37, bout=0, ovf=0.
- a=0x10, b=0x20 -> diff=0xF0, bout=1, ovf=0.
- a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1. Macro undefined: same diff, ovf=0.
- Start 0x5A-0x23, then start=1 with a=0xFF, b=0x00 on cycle 3 of RUN -> ignored; result 0x37. Start during DONE with a=0x00, b=0x01 -> back-to-back; diff=0xFF, bout=1.
- rst_n low at RUN cycle 4 -> busy=0, diff=0, no done pulse. Fresh 0x03-0x03 after release -> diff=0x00, bout=0.
- Randomized 500 operand pairs vs. reference model (a-b)[7:0] and borrow.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared state encoding, default width and counter sizing
// for the bit-serial arithmetic blocks.
package serial_arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Bits needed to count 0..w-1; never less than one.
    function automatic int cnt_width(input int w);
        int r;
        r = 0;
        while ((1 << r) < w) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: combinational 1-bit subtractor cell, d = x - y - bin.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout_cell
);

    assign d         = x ^ y ^ bin;
    assign bout_cell = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b with start/busy/done handshake.
// Define SERIAL_SUB_SIGNED_OVF_EN to build the signed overflow flag; otherwise ovf is 0.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] diff_sh;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             bnext;
    logic             last;

    full_subtractor u_cell (
        .x        (a_sh[0]),
        .y        (b_sh[0]),
        .bin      (borrow),
        .d        (d),
        .bout_cell(bnext)
    );

    assign last = cnt == CW'(WIDTH - 1);

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic [1:0] sign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q <= '0;
            ovf    <= 1'b0;
        end else if (state != S_RUN && start) begin
            sign_q <= {a[WIDTH-1], b[WIDTH-1]};
        end else if (state == S_RUN && last) begin
            ovf <= (sign_q[1] != sign_q[0]) && (d != sign_q[1]);
        end
    end
`else
    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
            a_sh    <= '0;
            b_sh    <= '0;
            diff_sh <= '0;
            borrow  <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    borrow  <= bnext;
                    diff_sh <= (WIDTH-1)'({d, diff_sh} >> 1);
                    // Counter holds at the terminal value rather than wrapping.
                    if (last) begin
                        diff  <= {d, diff_sh};
                        bout  <= bnext;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and randomized checks of serial_subtractor
// against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] last_diff = '0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .diff (diff),
        .bout (bout),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is observed,
    // so an immediate second call exercises start-during-DONE.
    task automatic do_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input int poke_cyc);
        int cyc, busy_n, dv, sv;
        logic got;
        logic exp_ovf;
        a = op_a;
        b = op_b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        cyc = 0;
        busy_n = 0;
        got = 1'b0;
        while (!got && cyc < 3 * W) begin
            @(negedge clk);
            cyc++;
            if (cyc == poke_cyc) begin
                start = 1'b1;
                a = 8'hFF;
                b = 8'h00;
            end else begin
                start = 1'b0;
            end
            if (done) got = 1'b1;
            else if (busy) busy_n++;
        end
        start = 1'b0;
        dv = int'(op_a) - int'(op_b);
        sv = int'($signed(op_a)) - int'($signed(op_b));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        exp_ovf = (sv > 127) || (sv < -128);
`else
        exp_ovf = 1'b0;
`endif
        check("latency", cyc, W + 1);
        check("busy_cycles", busy_n, W);
        check("busy_at_done", {31'b0, busy}, 0);
        check("diff", {24'b0, diff}, dv & 255);
        check("bout", {31'b0, bout}, {31'b0, dv < 0});
        check("ovf", {31'b0, ovf}, {31'b0, exp_ovf});
        last_diff = W'(dv & 255);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("done_pulse", {31'b0, done}, 0);
            check("hold_diff", {24'b0, diff}, {24'b0, last_diff});
        end
    endtask

    initial begin
        int seen;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_diff", {24'b0, diff}, 0);
        check("rst_bout", {31'b0, bout}, 0);
        check("rst_ovf", {31'b0, ovf}, 0);
        rst_n = 1'b1;
        gap(2);

        do_op(8'h5A, 8'h23, 0);
        gap(2);
        do_op(8'h10, 8'h20, 0);
        gap(1);
        do_op(8'h80, 8'h01, 0);
        gap(3);
        do_op(8'h5A, 8'h23, 3);
        do_op(8'h00, 8'h01, 0);
        gap(2);

        a = 8'h5A;
        b = 8'h23;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 0);
        check("abort_diff", {24'b0, diff}, 0);
        check("abort_bout", {31'b0, bout}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("abort_no_done", seen, 0);
        check("abort_idle", {31'b0, busy}, 0);
        last_diff = '0;
        do_op(8'h03, 8'h03, 0);
        gap(1);

        for (int n = 0; n < 500; n++) begin
            do_op(W'($urandom), W'($urandom), 0);
            gap($urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
